ps2_rx_decoder: RTL
===================

# ps2_rx_decoder

Receive-only PS/2 keyboard front end for the HID subsystem. It samples the raw PS/2 clock and data lines in the `msoc_clk` domain and removes clock glitches. It deframes 11-bit device-to-host frames and folds the `E0` (extended) and `F0` (break) prefix bytes into flags. Each completed key event appears as a single-cycle strobe whose code and flags map directly onto the keyboard FIFO write port: 8 data bits plus the released bit. The host-to-device (transmit) path is a separate block and is out of scope.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on `ps2_clk_i` and `ps2_data_i`; legal values ≥2.
- `FILTER_LEN`, default 8: consecutive identical synchronized clock samples required before the filtered clock changes; legal values ≥2.
- `TIMEOUT_CYCLES`, default 100000: idle `msoc_clk` cycles allowed between falling edges inside a frame (2 ms at 50 MHz).

Ports (one clock; reset is synchronous and active-low):
- `msoc_clk`  in  1  system clock; all state is updated on its rising edge.
- `rstn`  in  1  synchronous active-low reset.
- `ps2_clk_i`  in  1  raw PS/2 clock line, asynchronous.
- `ps2_data_i`  in  1  raw PS/2 data line, asynchronous.
- `scan_ready`  out  1  single-cycle strobe; a key event is valid.
- `scan_code`  out  8  scan code; held until the next event.
- `scan_released`  out  1  event was preceded by `F0`; held with `scan_code`.
- `scan_extended`  out  1  event was preceded by `E0`; held with `scan_code`.
- `parity_err`  out  1  single-cycle strobe; the frame failed the odd-parity check or the stop-bit check.
- `frame_err`  out  1  single-cycle strobe; the frame timed out mid-frame.

## Operation
- **Synchronizer:** both lines pass through `SYNC_STAGES` flops. Clock and data have identical delay.
- **Glitch filter:**
  - Run counter counts consecutive synchronized clock samples that differ from the filtered clock `fclk`.
  - `fclk` toggles when the count reaches `FILTER_LEN`.
  - The counter clears on any sample equal to `fclk`.
  - `fall` is a registered strobe, high for one cycle after `fclk` goes 1→0.
- **Sampling:** the FSM samples synchronized data only in cycles where `fall` is high.
- **FSM states:**
  - `IDLE`: a sampled 0 is a start bit; go to `DATA` with `bitcnt` cleared. A sampled 1 keeps the FSM in `IDLE`.
  - `DATA`: shift the sampled bit into `shreg` LSB-first. `bitcnt` is 3 bits. Go to `PARITY` after the 8th bit.
  - `PARITY`: store the parity bit; go to `STOP`.
  - `STOP`: the frame is good if the stop bit is 1 and `^{shreg, parity}` is 1 (odd parity). Always return to `IDLE`.
- **Good-frame handling:**
  - `shreg==8'hF0`: set `brk`; no strobe.
  - `shreg==8'hE0`: set `ext`; no strobe.
  - Any other byte, including `E1`: load `scan_code`, `scan_released=brk`, `scan_extended=ext`; pulse `scan_ready`; clear `brk` and `ext`.
- **Bad frame:** pulse `parity_err`; discard the byte; clear `brk` and `ext`.
- **Timeout:**
  - The timeout counter, sized `$clog2(TIMEOUT_CYCLES+1)` bits, clears on every `fall` and while in `IDLE`.
  - Outside `IDLE`, when it reaches `TIMEOUT_CYCLES`: return to `IDLE`, pulse `frame_err`, clear `brk` and `ext`.
  - The counter saturates; it never wraps.
- **Simultaneous events:**
  - If `fall` and the timeout occur in the same cycle, `fall` wins and the counter clears.
  - `scan_ready`, `parity_err` and `frame_err` are mutually exclusive by construction.
- **Reset:**
  - FSM→`IDLE`; `bitcnt`, `shreg`, counters, `brk`, `ext` cleared.
  - `fclk`=1; all synchronizer flops set to 1.
  - `scan_code`, `scan_released`, `scan_extended`, `scan_ready`, `parity_err`, `frame_err` all reset to 0.
  - Reset mid-frame discards the partial frame. The next start bit after reset is decoded normally.

## Timing
- A clean falling edge on `ps2_clk_i` produces `fall` exactly `SYNC_STAGES+FILTER_LEN+1` cycles after the first `msoc_clk` edge that samples it low.
- `scan_ready`, `parity_err` and `frame_err` assert 1 cycle after the `fall` of the stop bit. Total latency from the stop-bit clock edge is `SYNC_STAGES+FILTER_LEN+2` cycles.
- Strobes are exactly 1 cycle wide. There is no back-pressure: the consumer must accept in that cycle.
- `scan_code` and its flags change only in the `scan_ready` cycle.
- Clock pulses of `FILTER_LEN-1` cycles or shorter (low or high) never generate `fall`.
- Minimum supported PS/2 half-period: `SYNC_STAGES+FILTER_LEN+2` cycles.

## Test plan
- Frame `1C` (start 0, data `00111000` LSB-first, parity 0, stop 1) → one `scan_ready`, `scan_code=8'h1C`, `scan_released=0`, `scan_extended=0`.
- Frames `F0`,`1C` → no strobe after `F0`; one strobe after `1C` with `scan_code=8'h1C`, `scan_released=1`. A following frame `1C` → `scan_released=0`.
- Frames `E0`,`F0`,`75` → exactly one `scan_ready`, with `scan_code=8'h75`, `scan_released=1`, `scan_extended=1`.
- Frames `F0`, then `1C` with a flipped parity bit → `parity_err` pulse and no `scan_ready`. A following good frame `1C` → `scan_released=0`.
- Start bit and 4 data bits, then the clock held high for `TIMEOUT_CYCLES+10` cycles → one `frame_err` pulse, FSM in `IDLE`. A following frame `2A` → `scan_code=8'h2A`.
- A low glitch on `ps2_clk_i` of `FILTER_LEN-1` cycles in the middle of a data-bit half-period → frame decodes unchanged. Assert `rstn=0` during bit 5 → all outputs 0 and no strobe. The next full frame `1C` decodes correctly.

Source files
------------

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receive front end: synchronizes and deglitches the raw lines, deframes
// 11-bit device frames and folds E0/F0 prefixes into flags on a single-cycle key event.
module ps2_rx_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       msoc_clk,
    input  logic       rstn,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       scan_ready,
    output logic [7:0] scan_code,
    output logic       scan_released,
    output logic       scan_extended,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_p0;
    logic [SYNC_STAGES-1:0] data_sync_p0;
    logic                   s_clk;
    logic                   s_data;

    logic                   fclk_p1;
    logic                   fclk_d_p1;
    logic [FW-1:0]          run_cnt_p1;
    logic                   fall_p2;

    state_t                 state;
    logic [2:0]             bitcnt;
    logic [7:0]             shreg;
    logic                   parity;
    logic [TW-1:0]          tcnt;
    logic                   brk;
    logic                   ext;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TMAX) ? v : v + 1'b1;
    endfunction

    function automatic logic odd_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    assign s_clk  = clk_sync_p0[SYNC_STAGES-1];
    assign s_data = data_sync_p0[SYNC_STAGES-1];

    // Stage p0: synchronizers, idle-high so reset never looks like a start bit
    always_ff @(posedge msoc_clk) begin
        if (!rstn) begin
            clk_sync_p0  <= '1;
            data_sync_p0 <= '1;
        end else begin
            clk_sync_p0  <= {clk_sync_p0[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_p0 <= {data_sync_p0[SYNC_STAGES-2:0], ps2_data_i};
        end
    end

    // Stage p1/p2: run-length glitch filter and registered falling-edge strobe
    always_ff @(posedge msoc_clk) begin
        if (!rstn) begin
            fclk_p1    <= 1'b1;
            fclk_d_p1  <= 1'b1;
            run_cnt_p1 <= '0;
            fall_p2    <= 1'b0;
        end else begin
            fclk_d_p1 <= fclk_p1;
            fall_p2   <= fclk_d_p1 & ~fclk_p1;
            if (run_cnt_p1 == FILT_MAX) begin
                fclk_p1    <= ~fclk_p1;
                run_cnt_p1 <= '0;
            end else if (s_clk == fclk_p1) begin
                run_cnt_p1 <= '0;
            end else begin
                run_cnt_p1 <= run_cnt_p1 + 1'b1;
            end
        end
    end

    // Stage p3: frame FSM, prefix folding and registered event strobes
    always_ff @(posedge msoc_clk) begin
        if (!rstn) begin
            state         <= IDLE;
            bitcnt        <= '0;
            shreg         <= '0;
            parity        <= 1'b0;
            tcnt          <= '0;
            brk           <= 1'b0;
            ext           <= 1'b0;
            scan_ready    <= 1'b0;
            scan_code     <= '0;
            scan_released <= 1'b0;
            scan_extended <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            scan_ready <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || fall_p2) tcnt <= '0;
            else                          tcnt <= sat_inc(tcnt);

            // A falling edge takes priority over a coincident timeout
            if (fall_p2) begin
                case (state)
                    IDLE: begin
                        if (!s_data) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {s_data, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity <= s_data;
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (s_data && odd_ok(shreg, parity)) begin
                            if (shreg == 8'hF0) begin
                                brk <= 1'b1;
                            end else if (shreg == 8'hE0) begin
                                ext <= 1'b1;
                            end else begin
                                scan_code     <= shreg;
                                scan_released <= brk;
                                scan_extended <= ext;
                                scan_ready    <= 1'b1;
                                brk           <= 1'b0;
                                ext           <= 1'b0;
                            end
                        end else begin
                            parity_err <= 1'b1;
                            brk        <= 1'b0;
                            ext        <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tcnt == TMAX) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                brk       <= 1'b0;
                ext       <= 1'b0;
            end
        end
    end

endmodule
